adder_operand_fifo: RTL and testbench

Operand staging queue that sits directly upstream of the 32-bit ripple-carry adder stage (`adder_seq`). It buffers operand pairs from a producer behind a valid/ready handshake and presents the oldest pair on `in1`/`in2` for the adder to consume. It decouples bursty operand arrival from adder consumption and drives 0 + 0 onto the adder whenever the queue is empty.

---
 rtl/adder_operand_fifo.sv | 78 +++++++
 tb/tb_adder_operand_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_fifo.sv
// Operand-pair staging FIFO ahead of the ripple-carry adder; drives 0 + 0 when empty.
// Optional refused-push counter on port drop_cnt, enabled by defining ADDER_OPERAND_FIFO_DROP_CNT_EN.
module adder_operand_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_in1,
    input  logic [WIDTH-1:0]         push_in2,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         in1,
    output logic [WIDTH-1:0]         in2,
    output logic [$clog2(DEPTH):0]   count
`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_fire;
    logic             pop_fire;

    // Handshake status decodes only the registered count, so no input-to-output path exists.
    assign push_ready = (count != FULL_COUNT);
    assign pop_valid  = (count != '0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;

    assign in1 = pop_valid ? mem1[rd_ptr] : '0;
    assign in2 = pop_valid ? mem2[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem1[wr_ptr] <= push_in1;
            mem2[wr_ptr] <= push_in2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_fire)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push_fire && !pop_fire)
                count <= count + COUNT_ONE;
            else if (pop_fire && !push_fire)
                count <= count - COUNT_ONE;
        end
    end

`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (push_valid && !push_ready && drop_cnt != '1)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_adder_operand_fifo.sv
// Directed bench for adder_operand_fifo: queue-based reference model checked every cycle plus literal spot checks.
module tb_adder_operand_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             push_valid = 1'b0;
    logic             push_ready;
    logic [WIDTH-1:0] push_in1 = '0;
    logic [WIDTH-1:0] push_in2 = '0;
    logic             pop_valid;
    logic             pop_ready = 1'b0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       count;
`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    pair_t       q[$];
    logic [15:0] model_drop = '0;

    adder_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_in1   (push_in1),
        .push_in2   (push_in2),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .in1        (in1),
        .in2        (in2),
        .count      (count)
`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain queue of pairs updated from the handshake rules.
    always @(negedge rst_n) begin
        q.delete();
        model_drop = '0;
    end

    always @(posedge clk) begin
        bit can_push;
        bit can_pop;
        if (rst_n) begin
            can_push = (q.size() != DEPTH);
            can_pop  = (q.size() != 0);
            if (push_valid && !can_push && model_drop != 16'hFFFF)
                model_drop = model_drop + 16'd1;
            if (pop_ready && can_pop)
                void'(q.pop_front());
            if (push_valid && can_push)
                q.push_back('{a: push_in1, b: push_in2});
        end
    end

    always @(negedge clk) begin
        int sz;
        sz = q.size();
        check("cyc_count", 64'(count), 64'(sz));
        check("cyc_pop_valid", 64'(pop_valid), 64'(sz != 0));
        check("cyc_push_ready", 64'(push_ready), 64'(sz != DEPTH));
        check("cyc_in1", 64'(in1), (sz != 0) ? 64'(q[0].a) : 64'd0);
        check("cyc_in2", 64'(in2), (sz != 0) ? 64'(q[0].b) : 64'd0);
`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
        check("cyc_drop_cnt", 64'(drop_cnt), 64'(model_drop));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        push_valid = 1'b1;
        push_in1 = a;
        push_in2 = b;
        step();
        push_valid = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_pop_valid", 64'(pop_valid), 64'd0);
        check("rst_push_ready", 64'(push_ready), 64'd1);
        check("rst_in1", 64'(in1), 64'd0);
        check("rst_in2", 64'(in2), 64'd0);

        // Single push then pop
        push_one(32'h5, 32'h3);
        check("one_pop_valid", 64'(pop_valid), 64'd1);
        check("one_in1", 64'(in1), 64'd5);
        check("one_in2", 64'(in2), 64'd3);
        check("one_count", 64'(count), 64'd1);
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        check("one_pop_empty", 64'(pop_valid), 64'd0);
        check("one_in1_zero", 64'(in1), 64'd0);
        check("one_in2_zero", 64'(in2), 64'd0);

        // Fill, refused 5th push held 3 cycles, drain in order
        for (int i = 1; i <= 4; i++)
            push_one(WIDTH'(i), WIDTH'(100 + i));
        check("fill_count", 64'(count), 64'd4);
        check("fill_push_ready", 64'(push_ready), 64'd0);
        push_valid = 1'b1;
        push_in1 = 32'd5;
        push_in2 = 32'd105;
        step();
        step();
        step();
        push_valid = 1'b0;
        check("refused_count", 64'(count), 64'd4);
`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
        check("refused_drop_cnt", 64'(drop_cnt), 64'd3);
`endif
        for (int i = 1; i <= 4; i++) begin
            check("drain_in1", 64'(in1), 64'(i));
            check("drain_in2", 64'(in2), 64'(100 + i));
            pop_ready = 1'b1;
            step();
        end
        pop_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);

        // Full with simultaneous push and pop
        for (int i = 11; i <= 14; i++)
            push_one(WIDTH'(i), WIDTH'(200 + i));
        push_valid = 1'b1;
        push_in1 = 32'd15;
        push_in2 = 32'd215;
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        check("fullpp_count", 64'(count), 64'd3);
        check("fullpp_head", 64'(in1), 64'd12);
        step();
        push_valid = 1'b0;
        check("fullpp_refill", 64'(count), 64'd4);
`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
        check("fullpp_drop_cnt", 64'(drop_cnt), 64'd4);
`endif
        for (int j = 12; j <= 15; j++) begin
            check("fullpp_order", 64'(in1), 64'(j));
            pop_ready = 1'b1;
            step();
        end
        pop_ready = 1'b0;

        // Streaming across pointer wraps; first cycle is push+pop on empty
        push_valid = 1'b1;
        pop_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d = 32'hFFFF_FFF0 + WIDTH'(k);
            push_in1 = d;
            push_in2 = WIDTH'(k);
            step();
            check("stream_count", 64'(count), 64'd1);
            check("stream_in1", 64'(in1), 64'(d));
            check("stream_in2", 64'(in2), 64'(k));
        end
        push_valid = 1'b0;
        step();
        pop_ready = 1'b0;
        check("stream_end_count", 64'(count), 64'd0);

        // Asynchronous reset mid-cycle discards queued pairs
        push_one(32'd41, 32'd51);
        push_one(32'd42, 32'd52);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_pop_valid", 64'(pop_valid), 64'd0);
        check("arst_push_ready", 64'(push_ready), 64'd1);
        check("arst_in1", 64'(in1), 64'd0);
        step();
        rst_n = 1'b1;
`ifdef ADDER_OPERAND_FIFO_DROP_CNT_EN
        check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        push_one(32'd77, 32'd88);
        check("post_rst_in1", 64'(in1), 64'd77);
        check("post_rst_in2", 64'(in2), 64'd88);
        check("post_rst_count", 64'(count), 64'd1);
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
